// File: rtl/pn_pkg.sv
// pn_pkg: shared constants and types for the Polish-notation evaluator.
//   OP_*  : opcode encodings carried in the token payload
//   ERR_* : error codes reported on the err output
//   state_e : top-level FSM states
package pn_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ABS = 3'd3;
  localparam logic [2:0] OP_MAX = 3'd4;
  localparam logic [2:0] OP_MIN = 3'd5;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDER     = 2'd1;
  localparam logic [1:0] ERR_OVER      = 2'd2;
  localparam logic [1:0] ERR_MALFORMED = 2'd3;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, OUT} state_e;

endpackage

// File: rtl/pn_alu.sv
// pn_alu: combinational ALU for the evaluator.
//   a_i, b_i  : signed W-bit operands (result is a op b)
//   op_i      : opcode taken straight from the token payload
//   y_o       : W-bit wrapped result
//   invalid_o : opcode is not one of OP_ADD..OP_MIN
import pn_pkg::*;

module pn_alu #(
  parameter int W   = 32,
  parameter int OPW = 3
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [OPW-1:0] op_i,
  output logic [W-1:0]   y_o,
  output logic           invalid_o
);

  logic [OPW+2:0] opx;
  logic [2:0]     op3;
  logic [W-1:0]   sum;
  logic           a_gt_b;

  always_comb begin
    // Widen so the low 3 bits exist for any payload width; any set bit
    // above those makes the opcode invalid.
    opx       = {3'b000, op_i};
    op3       = opx[2:0];
    sum       = a_i + b_i;
    a_gt_b    = $signed(a_i) > $signed(b_i);
    y_o       = '0;
    invalid_o = (opx >> 3) != '0;
    case (op3)
      OP_ADD:  y_o = sum;
      OP_SUB:  y_o = a_i - b_i;
      OP_MUL:  y_o = a_i * b_i;
      // Negating min_int wraps back to min_int, which is the intended result.
      OP_ABS:  y_o = sum[W-1] ? (~sum + W'(1)) : sum;
      OP_MAX:  y_o = a_gt_b ? a_i : b_i;
      OP_MIN:  y_o = a_gt_b ? b_i : a_i;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pn_stream_eval.sv
// pn_stream_eval: prefix/postfix expression evaluator with a hardware stack.
//   clk, rst            : clock, asynchronous active-high reset
//   mode                : 0 prefix, 1 postfix (taken on the first beat)
//   operator, in        : token kind and payload
//   in_valid / in_ready : token stream handshake (ready in IDLE/LOAD)
//   out, err            : result (0 on error) and error code
//   out_valid/out_ready : result handshake, held until accepted
import pn_pkg::*;

module pn_stream_eval #(
  parameter int W           = 32,
  parameter int IN_W        = 3,
  parameter int DEPTH       = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic            operator,
  input  logic [IN_W-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out,
  output logic [1:0]      err,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SAW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   proc_q, proc_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    out_q, out_d;
  logic [1:0]      err_q, err_d;
  logic            ovalid_q, ovalid_d;

  logic            tok_op  [DEPTH];
  logic [IN_W-1:0] tok_val [DEPTH];
  logic [W-1:0]    stk     [STACK_DEPTH];

  logic [AW-1:0]   cur_a;
  logic            cur_op;
  logic [IN_W-1:0] cur_v;
  logic [W-1:0]    opnd;
  logic [SAW-1:0]  top_idx, nxt_idx;
  logic [W-1:0]    top_v, nxt_v, alu_a, alu_b, alu_y;
  logic            alu_inv;

  logic            tok_we;
  logic            push_en;
  logic [SAW-1:0]  push_idx;
  logic [W-1:0]    push_val;
  logic [SPW-1:0]  new_sp;
  logic [1:0]      eval_err;
  logic            last;

  // Token walk order: postfix 0..N-1, prefix N-1..0. Modular AW-bit math
  // is exact since every valid index is below DEPTH.
  assign cur_a  = mode_q ? proc_q[AW-1:0]
                         : (count_q[AW-1:0] - AW'(1) - proc_q[AW-1:0]);
  assign cur_op = tok_op[cur_a];
  assign cur_v  = tok_val[cur_a];
  assign opnd   = W'(cur_v);

  assign top_idx = sp_q[SAW-1:0] - SAW'(1);
  assign nxt_idx = sp_q[SAW-1:0] - SAW'(2);
  assign top_v   = stk[top_idx];
  assign nxt_v   = stk[nxt_idx];

  // Postfix pops b then a; prefix pops a then b.
  assign alu_a = mode_q ? nxt_v : top_v;
  assign alu_b = mode_q ? top_v : nxt_v;

  pn_alu #(.W(W), .OPW(IN_W)) u_alu (
    .a_i       (alu_a),
    .b_i       (alu_b),
    .op_i      (cur_v),
    .y_o       (alu_y),
    .invalid_o (alu_inv)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    proc_d   = proc_q;
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    out_d    = out_q;
    err_d    = err_q;
    ovalid_d = ovalid_q;
    tok_we   = 1'b0;
    push_en  = 1'b0;
    push_idx = sp_q[SAW-1:0];
    push_val = opnd;
    new_sp   = sp_q;
    eval_err = ERR_NONE;
    last     = (proc_q == count_q - CW'(1));
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tok_we  = 1'b1;
          mode_d  = mode;
          count_d = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (count_q == CW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            tok_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end else if (ovf_q) begin
          state_d  = OUT;
          err_d    = ERR_OVER;
          out_d    = '0;
          ovalid_d = 1'b1;
        end else begin
          state_d = EVAL;
          proc_d  = '0;
          sp_d    = '0;
        end
      end
      EVAL: begin
        if (cur_op) begin
          if (sp_q < SPW'(2)) begin
            eval_err = ERR_UNDER;
          end else if (alu_inv) begin
            eval_err = ERR_MALFORMED;
          end else begin
            // Result replaces the two popped entries.
            push_en  = 1'b1;
            push_idx = nxt_idx;
            push_val = alu_y;
            new_sp   = sp_q - SPW'(1);
          end
        end else begin
          if (sp_q == SPW'(STACK_DEPTH)) begin
            eval_err = ERR_OVER;
          end else begin
            push_en = 1'b1;
            new_sp  = sp_q + SPW'(1);
          end
        end
        // The end-of-expression check folds into the last token's cycle so
        // the result is ready right after it.
        if (eval_err == ERR_NONE && last && new_sp != SPW'(1)) begin
          eval_err = ERR_MALFORMED;
        end
        sp_d   = new_sp;
        proc_d = proc_q + CW'(1);
        if (eval_err != ERR_NONE) begin
          state_d  = OUT;
          err_d    = eval_err;
          out_d    = '0;
          ovalid_d = 1'b1;
        end else if (last) begin
          state_d  = OUT;
          err_d    = ERR_NONE;
          out_d    = push_val;
          ovalid_d = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d  = IDLE;
          ovalid_d = 1'b0;
          count_d  = '0;
          sp_d     = '0;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      count_q  <= '0;
      proc_q   <= '0;
      sp_q     <= '0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
      err_q    <= ERR_NONE;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      proc_q   <= proc_d;
      sp_q     <= sp_d;
      ovf_q    <= ovf_d;
      out_q    <= out_d;
      err_q    <= err_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Storage arrays carry no reset; count/sp gate every read.
  always_ff @(posedge clk) begin
    if (tok_we) begin
      tok_op[count_q[AW-1:0]]  <= operator;
      tok_val[count_q[AW-1:0]] <= in;
    end
    if (push_en) begin
      stk[push_idx] <= push_val;
    end
  end

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign out       = out_q;
  assign err       = err_q;
  assign out_valid = ovalid_q;

endmodule

// File: tb/tb_pn_stream_eval.sv
// Directed bench: a W=32 and a W=8 evaluator share one token stream; every
// frame's result, error code and latency is checked against hand values.
module tb_pn_stream_eval;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        operator = 1'b0;
  logic [2:0]  in_tok = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        ir32, ov32, ir8, ov8;
  logic [31:0] out32;
  logic [7:0]  out8;
  logic [1:0]  err32, err8;

  int checks = 0;
  int failures = 0;

  logic        fop[$];
  logic [2:0]  fval[$];

  always #5 clk = ~clk;

  pn_stream_eval #(.W(32), .IN_W(3), .DEPTH(16), .STACK_DEPTH(8)) d32 (
    .clk(clk), .rst(rst), .mode(mode), .operator(operator), .in(in_tok),
    .in_valid(in_valid), .in_ready(ir32), .out(out32), .err(err32),
    .out_valid(ov32), .out_ready(out_ready)
  );

  pn_stream_eval #(.W(8), .IN_W(3), .DEPTH(16), .STACK_DEPTH(8)) d8 (
    .clk(clk), .rst(rst), .mode(mode), .operator(operator), .in(in_tok),
    .in_valid(in_valid), .in_ready(ir8), .out(out8), .err(err8),
    .out_valid(ov8), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tok(input logic o, input logic [2:0] v);
    fop.push_back(o);
    fval.push_back(v);
  endtask

  task automatic send_frame(input logic m);
    foreach (fop[i]) begin
      @(negedge clk);
      in_valid = 1'b1; mode = m; operator = fop[i]; in_tok = fval[i];
    end
    @(negedge clk);
    in_valid = 1'b0; operator = 1'b0; in_tok = '0;
    fop.delete();
    fval.delete();
  endtask

  // lat = number of edges after E0 before out_valid is seen.
  task automatic wait_out(output int lat);
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov32 && lat < 100);
  endtask

  task automatic run(input string tag, input logic m, input logic [31:0] e32,
                     input logic [7:0] e8, input logic [1:0] eerr, input int elat);
    int lat;
    send_frame(m);
    wait_out(lat);
    check({tag, ".lat"},   64'(lat), 64'(elat));
    check({tag, ".out32"}, out32, e32);
    check({tag, ".err32"}, err32, eerr);
    check({tag, ".ov8"},   ov8, 1'b1);
    check({tag, ".out8"},  out8, e8);
    check({tag, ".err8"},  err8, eerr);
    @(negedge clk);
    check({tag, ".ovlow"}, ov32, 1'b0);
    check({tag, ".irdy"},  ir32, 1'b1);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    check("rst.out",   out32, 32'd0);
    check("rst.err",   err32, 2'd0);
    check("rst.ovld",  ov32, 1'b0);
    check("rst.irdy",  ir32, 1'b1);
    rst = 1'b0;

    // 3 4 + 2 * = 14
    tok(0,3); tok(0,4); tok(1,0); tok(0,2); tok(1,2);
    run("pf_mul", 1'b1, 32'd14, 8'd14, 2'd0, 5);

    // prefix - 2 5 = -3
    tok(1,1); tok(0,2); tok(0,5);
    run("pre_sub", 1'b0, 32'hFFFF_FFFD, 8'hFD, 2'd0, 3);

    // 7 7 * 7 * = 343; 87 at W=8
    tok(0,7); tok(0,7); tok(1,2); tok(0,7); tok(1,2);
    run("pf_wrap", 1'b1, 32'd343, 8'd87, 2'd0, 5);

    // min(max(3,5),6) = 5
    tok(0,3); tok(0,5); tok(1,4); tok(0,6); tok(1,5);
    run("maxmin", 1'b1, 32'd5, 8'd5, 2'd0, 5);

    // min(0-1, 2) = -1, signed compare
    tok(0,0); tok(0,1); tok(1,1); tok(0,2); tok(1,5);
    run("min_neg", 1'b1, 32'hFFFF_FFFF, 8'hFF, 2'd0, 5);

    // |(1-5)+0| = 4
    tok(0,1); tok(0,5); tok(1,1); tok(0,0); tok(1,3);
    run("abs", 1'b1, 32'd4, 8'd4, 2'd0, 5);

    tok(0,5);
    run("single", 1'b0, 32'd5, 8'd5, 2'd0, 1);

    tok(0,1); tok(1,0);
    run("under", 1'b1, 32'd0, 8'd0, 2'd1, 2);

    tok(0,1); tok(0,2);
    run("leftover", 1'b1, 32'd0, 8'd0, 2'd3, 2);

    tok(0,1); tok(0,2); tok(1,6);
    run("badop", 1'b1, 32'd0, 8'd0, 2'd3, 3);

    // Nine pushes into an eight-entry stack
    for (int i = 0; i < 9; i++) tok(0, 3'd1);
    run("stk_ovf", 1'b1, 32'd0, 8'd0, 2'd2, 9);

    // DEPTH+1 beats with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) tok(0, 3'd1);
    send_frame(1'b1);
    wait_out(lat);
    check("tok_ovf.lat", 64'(lat), 64'd0);
    check("tok_ovf.err", err32, 2'd2);
    check("tok_ovf.out", out32, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold.ovld", ov32, 1'b1);
      check("hold.err",  err32, 2'd2);
      check("hold.out",  out32, 32'd0);
      check("hold.irdy", ir32, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("xfer.ovld", ov32, 1'b0);
    check("xfer.irdy", ir32, 1'b1);

    // Reset in the middle of evaluation
    tok(0,3); tok(0,4); tok(1,0); tok(0,2); tok(1,2);
    send_frame(1'b1);
    repeat (2) @(negedge clk);
    check("mid.irdy_low", ir32, 1'b0);
    rst = 1'b1;
    #1;
    check("mid.ovld", ov32, 1'b0);
    check("mid.irdy", ir32, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    tok(0,2); tok(0,3); tok(1,0);
    run("post_rst", 1'b1, 32'd5, 8'd5, 2'd0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
